// File: rtl/xtea_pkg.sv
// Shared constants for the iomem XTEA coprocessor: round constant, register map,
// control/status bit positions, FSM encoding and a byte-strobe merge helper.
package xtea_pkg;

  localparam logic [31:0] DELTA = 32'h9E37_79B9;

  // Word offsets, i.e. iomem_addr[7:2]
  localparam logic [5:0] REG_CTRL    = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h01;
  localparam logic [5:0] REG_KEY0    = 6'h02;
  localparam logic [5:0] REG_KEY1    = 6'h03;
  localparam logic [5:0] REG_KEY2    = 6'h04;
  localparam logic [5:0] REG_KEY3    = 6'h05;
  localparam logic [5:0] REG_DATA0   = 6'h06;
  localparam logic [5:0] REG_DATA1   = 6'h07;
  localparam logic [5:0] REG_RESULT0 = 6'h08;
  localparam logic [5:0] REG_RESULT1 = 6'h09;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_DONE  = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/xtea_half_round.sv
// One XTEA half-round: updates either v0 or v1 depending on step parity and
// direction, and steps sum after the first half of each cycle.
module xtea_half_round
  import xtea_pkg::*;
(
  input  logic [31:0]      v0_i,
  input  logic [31:0]      v1_i,
  input  logic [31:0]      sum_i,
  input  logic [3:0][31:0] key_i,
  input  logic             decrypt_i,
  input  logic             odd_i,
  output logic [31:0]      v0_o,
  output logic [31:0]      v1_o,
  output logic [31:0]      sum_o
);

  logic        upd_v0;
  logic [1:0]  key_idx;
  logic [31:0] src, tgt, mix, f, res;

  // Encrypt-even and decrypt-odd both rewrite v0 from a mix of v1 keyed by sum[1:0]
  assign upd_v0  = (odd_i == decrypt_i);
  assign src     = upd_v0 ? v1_i : v0_i;
  assign tgt     = upd_v0 ? v0_i : v1_i;
  assign key_idx = upd_v0 ? sum_i[1:0] : sum_i[12:11];

  assign mix = ((src << 4) ^ (src >> 5)) + src;
  assign f   = mix ^ (sum_i + key_i[key_idx]);
  assign res = decrypt_i ? (tgt - f) : (tgt + f);

  assign v0_o  = upd_v0 ? res  : v0_i;
  assign v1_o  = upd_v0 ? v1_i : res;
  assign sum_o = odd_i ? sum_i : (decrypt_i ? (sum_i - DELTA) : (sum_i + DELTA));

endmodule

// File: rtl/iomem_xtea_copro.sv
// Memory-mapped XTEA coprocessor on the iomem bus, one half-round per cycle.
// Optional `XTEA_AUTOINC_EN: the 64-bit DATA block increments on completion.
module iomem_xtea_copro
  import xtea_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned ROUNDS    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [7:0]  LAST_CNT = 8'(2 * ROUNDS - 1);
  localparam logic [31:0] DEC_SUM  = DELTA * ROUNDS;

  logic             ready_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0][31:0] key_q, key_d, ekey_q, ekey_d;
  logic [1:0][31:0] data_q, data_d, result_q, result_d;
  logic             decrypt_q, decrypt_d, irq_en_q, irq_en_d, done_q, done_d, edec_q, edec_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [31:0]      hr_v0, hr_v1, hr_sum;

  logic       sel, acc, wr, busy, start, done_clr, data_wr;
  logic [5:0] woff;
  logic       unused_addr_lsbs;

  assign sel  = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign acc  = sel && !ready_q;
  assign wr   = acc && (|iomem_wstrb);
  assign woff = iomem_addr[7:2];
  assign busy = (state_q != ST_IDLE);
  assign unused_addr_lsbs = ^iomem_addr[1:0];

  xtea_half_round u_half_round (
    .v0_i      (v0_q),
    .v1_i      (v1_q),
    .sum_i     (sum_q),
    .key_i     (ekey_q),
    .decrypt_i (edec_q),
    .odd_i     (cnt_q[0]),
    .v0_o      (hr_v0),
    .v1_o      (hr_v1),
    .sum_o     (hr_sum)
  );

  // Bus writes, then FSM. START sees the DATA/KEY/DECRYPT values written in the same access.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    key_d     = key_q;
    data_d    = data_q;
    decrypt_d = decrypt_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    start     = 1'b0;
    done_clr  = 1'b0;
    data_wr   = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    sum_d     = sum_q;
    ekey_d    = ekey_q;
    edec_d    = edec_q;
    result_d  = result_q;

    if (wr) begin
      case (woff)
        REG_CTRL: if (iomem_wstrb[0]) begin
          start     = iomem_wdata[CTRL_START];
          decrypt_d = iomem_wdata[CTRL_DECRYPT];
          irq_en_d  = iomem_wdata[CTRL_IRQ_EN];
        end
        REG_STATUS: done_clr = iomem_wstrb[0] && iomem_wdata[STATUS_DONE];
        REG_KEY0:  key_d[0] = merge_bytes(key_q[0], iomem_wdata, iomem_wstrb);
        REG_KEY1:  key_d[1] = merge_bytes(key_q[1], iomem_wdata, iomem_wstrb);
        REG_KEY2:  key_d[2] = merge_bytes(key_q[2], iomem_wdata, iomem_wstrb);
        REG_KEY3:  key_d[3] = merge_bytes(key_q[3], iomem_wdata, iomem_wstrb);
        REG_DATA0: begin
          data_d[0] = merge_bytes(data_q[0], iomem_wdata, iomem_wstrb);
          data_wr   = 1'b1;
        end
        REG_DATA1: begin
          data_d[1] = merge_bytes(data_q[1], iomem_wdata, iomem_wstrb);
          data_wr   = 1'b1;
        end
        default: ;
      endcase
    end

    if (done_clr) done_d = 1'b0;

    case (state_q)
      ST_IDLE: if (start) begin
        v0_d    = data_d[0];
        v1_d    = data_d[1];
        ekey_d  = key_d;
        edec_d  = decrypt_d;
        sum_d   = decrypt_d ? DEC_SUM : 32'd0;
        cnt_d   = 8'd0;
        done_d  = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        v0_d  = hr_v0;
        v1_d  = hr_v1;
        sum_d = hr_sum;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) state_d = ST_FIN;
      end
      ST_FIN: begin
        // Completion overrides a same-cycle DONE clear
        result_d = {v1_q, v0_q};
        done_d   = 1'b1;
        state_d  = ST_IDLE;
`ifdef XTEA_AUTOINC_EN
        if (!data_wr) data_d = data_q + 64'd1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    if (acc) begin
      case (woff)
        REG_CTRL:    rdata_d = {29'd0, irq_en_q, decrypt_q, 1'b0};
        REG_STATUS:  rdata_d = {30'd0, done_q, busy};
        REG_KEY0:    rdata_d = key_q[0];
        REG_KEY1:    rdata_d = key_q[1];
        REG_KEY2:    rdata_d = key_q[2];
        REG_KEY3:    rdata_d = key_q[3];
        REG_DATA0:   rdata_d = data_q[0];
        REG_DATA1:   rdata_d = data_q[1];
        REG_RESULT0: rdata_d = result_q[0];
        REG_RESULT1: rdata_d = result_q[1];
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      key_q     <= '0;
      data_q    <= '0;
      result_q  <= '0;
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      v0_q      <= '0;
      v1_q      <= '0;
      sum_q     <= '0;
      ekey_q    <= '0;
      edec_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      ready_q   <= acc;
      rdata_q   <= rdata_d;
      key_q     <= key_d;
      data_q    <= data_d;
      result_q  <= result_d;
      decrypt_q <= decrypt_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      sum_q     <= sum_d;
      ekey_q    <= ekey_d;
      edec_q    <= edec_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = done_q & irq_en_q;

endmodule
